// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 3-digit status display: segment patterns and the
// status codes that the status logic and its consumers agree on.
package seg_scan_driver_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [11:0] STATUS_MEM_UNCAL = 12'h500;
  localparam logic [11:0] STATUS_MEM_ERR   = 12'h501;
  localparam logic [11:0] STATUS_DEFAULT   = 12'h100;

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Hex nibble to active-high 7-segment pattern; polarity is the caller's job.
module hex_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves pattern unassigned (no latch).
    pattern = SEG_0;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 3-digit 7-segment scanner: latches the status word once per frame,
// scans one digit per slot and blanks the head of every slot to avoid ghosting.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned DIV_CYCLES     = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] seg_digits,
  input  logic [2:0]  dp_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  an,
  output logic        frame_tick
);

  localparam int unsigned      CNT_W     = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  localparam logic PH_BLANK = 1'b0;
  localparam logic PH_SHOW  = 1'b1;

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       dig_idx;
  logic [11:0]      digits_q;
  logic [2:0]       dp_q;

  logic       slot_wrap;
  logic       frame_latch;
  logic       phase;
  logic [3:0] nibble;
  logic       dp_sel;
  logic [2:0] an_onehot;
  logic [6:0] seg_pattern;

  assign slot_wrap   = (slot_cnt == CNT_LAST);
  assign frame_latch = slot_wrap && (dig_idx == 2'd2);
  assign phase       = (slot_cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;

  always_comb begin
    nibble    = digits_q[3:0];
    dp_sel    = dp_q[0];
    an_onehot = 3'b001;
    case (dig_idx)
      2'd1: begin
        nibble    = digits_q[7:4];
        dp_sel    = dp_q[1];
        an_onehot = 3'b010;
      end
      2'd2: begin
        nibble    = digits_q[11:8];
        dp_sel    = dp_q[2];
        an_onehot = 3'b100;
      end
      default: ;
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .nibble  (nibble),
    .pattern (seg_pattern)
  );

  // Scan counter and frame latch; the latched copy only moves at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      dig_idx    <= 2'd0;
      digits_q   <= 12'h000;
      dp_q       <= 3'b000;
      frame_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      frame_tick <= frame_latch;
      if (slot_wrap) begin
        slot_cnt <= '0;
        dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
      if (frame_latch) begin
        digits_q <= seg_digits;
        dp_q     <= dp_en;
      end
    end
  end

  // Pin drivers are registered; the blank phase at each slot head keeps any
  // two digit enables from overlapping when dig_idx changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else if (phase == PH_SHOW) begin
      seg <= SEG_ACTIVE_LOW ? ~seg_pattern : seg_pattern;
      dp  <= SEG_ACTIVE_LOW ? ~dp_sel : dp_sel;
      an  <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
    end else begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an 8-cycle slot and 2-cycle blank,
// both polarities active-low; every frame cycle is compared against a local model.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  localparam int FRAME = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] seg_digits = 12'h000;
  logic [2:0]  dp_en = 3'b000;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  seg_scan_driver #(
    .DIV_CYCLES     (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_digits (seg_digits),
    .dp_en      (dp_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent active-high decode table used as the bench's reference.
  function automatic logic [6:0] ref_pat(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Never more than one digit enable low, on any cycle.
  always @(negedge clk) begin
    if (mon_en) check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  // Runs one frame starting at a frame_tick sample point (or reset release) and
  // checks every cycle; optionally changes seg_digits at sample n=chg_n.
  task automatic run_frame(input logic [11:0] word, input logic [2:0] dpv, input string tag,
                           input int chg_n, input logic [11:0] chg_word,
                           output logic [6:0] seg0, output logic dp0);
    int pos, slot, cnt;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    seg0 = 7'h7F;
    dp0  = 1'b1;
    for (int n = 1; n <= FRAME; n++) begin
      @(negedge clk);
      if (n == chg_n) seg_digits = chg_word;
      pos  = n - 1;
      slot = pos / 8;
      cnt  = pos % 8;
      if (cnt < 2) begin
        e_an = 3'b111; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(3'b001 << slot);
        e_seg = ~ref_pat(word[4*slot +: 4]);
        e_dp  = ~dpv[slot];
      end
      check($sformatf("%s n=%0d an", tag, n), 32'(an), 32'(e_an));
      check($sformatf("%s n=%0d seg", tag, n), 32'(seg), 32'(e_seg));
      check($sformatf("%s n=%0d dp", tag, n), 32'(dp), 32'(e_dp));
      check($sformatf("%s n=%0d frame_tick", tag, n), 32'(frame_tick), 32'(n == FRAME));
      if (n == 3) begin
        seg0 = seg;
        dp0  = dp;
      end
    end
  endtask

  typedef struct {
    logic [11:0] digits;
    logic [2:0]  dpv;
    logic [6:0]  exp_seg0;
    logic        exp_dp0;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [6:0]  s0;
    logic        d0;
    logic [11:0] cur_word;
    logic [2:0]  cur_dp;
    int          gap;

    // Active-low expected slot-0 patterns, hand-inverted from the decode table.
    vecs[0]  = '{12'h000, 3'b001, 7'h40, 1'b0};
    vecs[1]  = '{12'h001, 3'b001, 7'h79, 1'b0};
    vecs[2]  = '{12'h002, 3'b001, 7'h24, 1'b0};
    vecs[3]  = '{12'h003, 3'b001, 7'h30, 1'b0};
    vecs[4]  = '{12'h004, 3'b001, 7'h19, 1'b0};
    vecs[5]  = '{12'h005, 3'b001, 7'h12, 1'b0};
    vecs[6]  = '{12'h006, 3'b001, 7'h02, 1'b0};
    vecs[7]  = '{12'h007, 3'b001, 7'h78, 1'b0};
    vecs[8]  = '{12'h008, 3'b001, 7'h00, 1'b0};
    vecs[9]  = '{12'h009, 3'b001, 7'h10, 1'b0};
    vecs[10] = '{12'h00A, 3'b001, 7'h08, 1'b0};
    vecs[11] = '{12'h00B, 3'b001, 7'h03, 1'b0};
    vecs[12] = '{12'h00C, 3'b001, 7'h46, 1'b0};
    vecs[13] = '{12'h00D, 3'b001, 7'h21, 1'b0};
    vecs[14] = '{12'h00E, 3'b001, 7'h06, 1'b0};
    vecs[15] = '{12'h00F, 3'b001, 7'h0E, 1'b0};

    // Reset state
    seg_digits = STATUS_MEM_ERR;
    #1 rst_n = 1'b0;
    #1;
    check("reset an", 32'(an), 32'h7);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp", 32'(dp), 32'h1);
    check("reset frame_tick", 32'(frame_tick), 32'h0);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame shows 000; second shows 501 (latched at the end of frame 1).
    run_frame(12'h000, 3'b000, "frame1", 0, 12'h000, s0, d0);
    seg_digits = STATUS_DEFAULT;
    run_frame(STATUS_MEM_ERR, 3'b000, "frame2", 0, 12'h000, s0, d0);
    check("frame2 slot0 seg", 32'(s0), 32'h79);

    // Tearing: 100 is latched; 013 arrives during dig_idx=1 and must wait a frame.
    run_frame(STATUS_DEFAULT, 3'b000, "tear", 10, 12'h013, s0, d0);
    check("tear slot0 seg", 32'(s0), 32'h40);
    run_frame(12'h013, 3'b000, "after_tear", 0, 12'h000, s0, d0);
    check("after_tear slot0 seg", 32'(s0), 32'h30);

    // Decode sweep on the rightmost digit with the slot-0 decimal point requested.
    cur_word = 12'h013;
    cur_dp   = 3'b000;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        seg_digits = vecs[i].digits;
        dp_en      = vecs[i].dpv;
      end
      run_frame(cur_word, cur_dp, $sformatf("sweep%0d", i), 0, 12'h000, s0, d0);
      if (i > 0) begin
        check($sformatf("sweep %0h seg0", i - 1), 32'(s0), 32'(vecs[i-1].exp_seg0));
        check($sformatf("sweep %0h dp0", i - 1), 32'(d0), 32'(vecs[i-1].exp_dp0));
      end
      if (i < 16) begin
        cur_word = vecs[i].digits;
        cur_dp   = vecs[i].dpv;
      end
    end

    // frame_tick spacing over 10 frames, bounded.
    for (int f = 0; f < 10; f++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!frame_tick && gap < 100);
      check($sformatf("tick period %0d", f), 32'(gap), 32'(FRAME));
    end

    // Asynchronous reset in the SHOW part of slot 2 (display holds 00F).
    for (int n = 1; n <= 20; n++) @(negedge clk);
    check("pre-reset an", 32'(an), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async an", 32'(an), 32'h7);
    check("async seg", 32'(seg), 32'h7F);
    check("async dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check($sformatf("restart n=%0d an", n), 32'(an), (n < 3) ? 32'h7 : 32'h6);
    end
    check("restart seg", 32'(seg), 32'h40);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
